uart_ram_loader: RTL and testbench

- Boot/image loader that feeds the on-FPGA synchronous single-port RAM over its write port (clk, enw, address, wdata).
- Receives a length-prefixed stream of little-endian 32-bit words on a UART RX line (8N1).
- Writes the words to consecutive RAM word addresses starting at 0, then asserts done so the CPU can be released from reset.
- Sits between the board UART pin and the RAM; the RAM read port is untouched.

---
 rtl/uart_ram_loader_if.sv | 13 +
 rtl/uart_ram_loader.sv | 178 +++++++++++++++++
 tb/tb_uart_ram_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_ram_loader_if.sv
// RAM write-port bundle driven by the loader and consumed by the RAM.
// enw is a single-cycle strobe with no back-pressure: the slave must accept
// address/wdata in every cycle where enw is high; both hold between strobes.
interface uart_ram_loader_if #(
   parameter int WIDTH = 32
) ();
   logic             enw;
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] wdata;

   modport master (output enw, address, wdata);
   modport slave  (input  enw, address, wdata);
endinterface

// File: rtl/uart_ram_loader.sv
// Boot loader: receives a length-prefixed little-endian word stream on an
// 8N1 UART line and writes it to RAM words 0..N-1, then raises done.
module uart_ram_loader #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 100_000,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   uart_ram_loader_if.master        ram,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [1:0]               o_dbg_rx_state,
   output logic [2:0]               o_dbg_ld_state
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_WRITE, LD_DONE, LD_ERROR} ld_state_t;

   logic             r_rx_meta, r_rx_sync;
   rx_state_t        r_rx_state, w_rx_next;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             w_cnt_zero, w_byte_valid, w_frame_err, w_start_ok;

   ld_state_t        r_ld_state, w_ld_next;
   logic [1:0]       r_byte_cnt;
   logic [WIDTH-1:0] r_asm, w_asm_next;
   logic [WIDTH-1:0] r_len, r_widx, r_address, r_wdata;
   logic             r_busy;
   logic             w_collect;

   // rx is asynchronous to clk; two flops before any decision is made on it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) r_rx_state <= RX_IDLE;
      else     r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next    = r_rx_state;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;
      w_start_ok   = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
         RX_START: if (w_cnt_zero) begin
            if (!r_rx_sync) begin
               w_rx_next  = RX_DATA;
               w_start_ok = 1'b1;
            end else begin
               w_rx_next  = RX_IDLE;
            end
         end
         RX_DATA:  if (w_cnt_zero && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_cnt_zero) begin
            w_rx_next    = RX_IDLE;
            w_byte_valid = r_rx_sync;
            w_frame_err  = !r_rx_sync;
         end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               r_cnt     <= CW'(CLKS_PER_BIT / 2);
               r_bit_idx <= '0;
            end
            RX_START: r_cnt <= w_cnt_zero ? CW'(CLKS_PER_BIT - 1) : r_cnt - 1'b1;
            RX_DATA: begin
               if (w_cnt_zero) begin
                  r_shift   <= {r_rx_sync, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_cnt     <= CW'(CLKS_PER_BIT - 1);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RX_STOP: if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= '0;
         endcase
      end
   end

   // Bytes land in their little-endian lane, so byte 0 ends up in bits 7:0
   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[{r_byte_cnt, 3'b000} +: 8] = r_shift;
   end

   assign w_collect = w_byte_valid && (r_ld_state == LD_LEN || r_ld_state == LD_DATA);

   always_ff @(posedge clk) begin
      if (rst) r_ld_state <= LD_LEN;
      else     r_ld_state <= w_ld_next;
   end

   always_comb begin
      w_ld_next = r_ld_state;
      case (r_ld_state)
         LD_LEN: begin
            if (w_frame_err) w_ld_next = LD_ERROR;
            else if (w_byte_valid && r_byte_cnt == 2'd3) begin
               if (w_asm_next == '0)                w_ld_next = LD_DONE;
               else if (w_asm_next > WIDTH'(DEPTH)) w_ld_next = LD_ERROR;
               else                                 w_ld_next = LD_DATA;
            end
         end
         LD_DATA: begin
            if (w_frame_err) w_ld_next = LD_ERROR;
            else if (w_byte_valid && r_byte_cnt == 2'd3) w_ld_next = LD_WRITE;
         end
         LD_WRITE: w_ld_next = (r_widx + WIDTH'(1) == r_len) ? LD_DONE : LD_DATA;
         LD_DONE:  w_ld_next = LD_DONE;
         LD_ERROR: w_ld_next = LD_ERROR;
         default:  w_ld_next = LD_ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_asm      <= '0;
         r_len      <= '0;
         r_widx     <= '0;
         r_address  <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
      end else begin
         if (w_collect) begin
            r_asm      <= w_asm_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         if (w_collect && r_byte_cnt == 2'd3) begin
            if (r_ld_state == LD_LEN) begin
               r_len <= w_asm_next;
            end else begin
               r_address <= r_widx;
               r_wdata   <= w_asm_next;
            end
         end
         if (r_ld_state == LD_WRITE) r_widx <= r_widx + WIDTH'(1);
         if (w_ld_next == LD_DONE || w_ld_next == LD_ERROR) r_busy <= 1'b0;
         else if (w_start_ok)                               r_busy <= 1'b1;
      end
   end

   assign ram.enw        = (r_ld_state == LD_WRITE);
   assign ram.address    = r_address;
   assign ram.wdata      = r_wdata;
   assign busy           = r_busy;
   assign done           = (r_ld_state == LD_DONE);
   assign error          = (r_ld_state == LD_ERROR);
   assign o_dbg_rx_state = r_rx_state;
   assign o_dbg_ld_state = r_ld_state;
endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: serial driver, write scoreboard, status checks.
module tb_uart_ram_loader;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       busy, done, error;
   logic [1:0] dbg_rx;
   logic [2:0] dbg_ld;

   logic [63:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_pulses = 0;

   uart_ram_loader_if #(.WIDTH(32)) ram ();

   uart_ram_loader #(.WIDTH(32), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .ram(ram),
      .busy(busy), .done(done), .error(error),
      .o_dbg_rx_state(dbg_rx), .o_dbg_ld_state(dbg_ld)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (ram.enw !== 1'b0) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write", ram.address, ram.wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("write_addr", {32'h0, ram.address}, {32'h0, e[63:32]});
            check("write_data", {32'h0, ram.wdata},   {32'h0, e[31:0]});
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      n_pulses = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enw"},     {63'h0, ram.enw}, 64'h0);
      check({tag, "_address"}, {32'h0, ram.address}, 64'h0);
      check({tag, "_wdata"},   {32'h0, ram.wdata}, 64'h0);
      check({tag, "_status"},  {61'h0, busy, done, error}, 64'h0);
   endtask

   initial begin
      // Reset state
      do_reset();
      check_reset_outputs("reset");
      check("reset_fsm", {59'h0, dbg_rx, dbg_ld}, 64'h0);

      // Two words
      exp_q.push_back({32'd0, 32'h12345678});
      exp_q.push_back({32'd1, 32'hDEADBEEF});
      send_word(32'd2);
      check("two_busy_mid", {63'h0, busy}, 64'h1);
      send_word(32'h12345678);
      send_word(32'hDEADBEEF);
      repeat (4) @(negedge clk);
      check("two_status", {61'h0, busy, done, error}, 64'b010);
      check("two_pulses", 64'(n_pulses), 64'd2);
      check("two_pending", 64'(exp_q.size()), 64'd0);
      check("two_hold_addr", {32'h0, ram.address}, 64'd1);

      // Zero length
      do_reset();
      send_word(32'd0);
      check("zero_status", {61'h0, busy, done, error}, 64'b010);
      check("zero_pulses", 64'(n_pulses), 64'd0);

      // Length above DEPTH, then 20 ignored bytes
      do_reset();
      send_word(32'd5);
      check("len_err_status", {61'h0, busy, done, error}, 64'b001);
      for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 1), 1'b1);
      check("len_err_after", {61'h0, busy, done, error}, 64'b001);
      check("len_err_pulses", 64'(n_pulses), 64'd0);

      // Framing error on the third data byte
      do_reset();
      send_word(32'd1);
      send_byte(8'h0D, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'hFE, 1'b0);
      send_byte(8'hCA, 1'b1);
      check("frame_status", {61'h0, busy, done, error}, 64'b001);
      check("frame_pulses", 64'(n_pulses), 64'd0);
      check("frame_addr", {32'h0, ram.address}, 64'd0);

      // Start-bit glitch must not produce a byte
      do_reset();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_fsm", {59'h0, dbg_rx, dbg_ld}, 64'h0);
      check("glitch_status", {61'h0, busy, done, error}, 64'b000);
      send_word(32'd0);
      check("glitch_then_frame", {61'h0, busy, done, error}, 64'b010);

      // Reset mid-stream, then a clean resend
      do_reset();
      send_word(32'd1);
      send_byte(8'h0D, 1'b1);
      send_byte(8'hF0, 1'b1);
      do_reset();
      check_reset_outputs("midrst");
      exp_q.push_back({32'd0, 32'hCAFEF00D});
      send_word(32'd1);
      send_word(32'hCAFEF00D);
      repeat (4) @(negedge clk);
      check("resend_status", {61'h0, busy, done, error}, 64'b010);
      check("resend_pulses", 64'(n_pulses), 64'd1);
      check("resend_pending", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
